seven_seg_scan_driver: RTL
==========================

// Module: seven_seg_scan_driver
// PURPOSE
// - Time-multiplexed driver for a DIGITS-wide common-select 7-segment display bank.
// - Captures a packed 4-bit-per-digit value, scans digits one at a time and decodes each nibble to segments.
// - Modes: BCD, hex and leading-zero blanking.
// - Sits between the counter/datapath logic and the board display pins; replaces one static decoder per digit.
// PARAMETERS
// - DIGITS     4      number of digits scanned (>=2); digit 0 = least significant, bits [3:0]
// - SCAN_DIV   50000  clk cycles per digit slot (>=2)
// - ACTIVE_LOW 1      1: segments and digit selects asserted low; 0: asserted high
// PORTS
// - clk         in   1          single clock; all state on rising edge
// - reset       in   1          asynchronous, active-low reset
// - value_in    in   4*DIGITS   packed nibbles; sampled only when load=1
// - load        in   1          capture value_in into shadow register on this edge
// - enable      in   1          0: display dark (all outputs inactive), scan counters keep running
// - hex_mode    in   1          1: nibbles 10-15 show A,b,C,d,E,F; 0: nibbles 10-15 blank
// - blank_lz    in   1          1: suppress leading zeros (digit 0 always shown)
// - seg_out     out  7          segments {g,f,e,d,c,b,a}, registered
// - dig_sel     out  DIGITS     one-hot digit select, registered
// - scan_tick   out  1          1-cycle pulse when the active digit advances
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - shadow=0, digit index=0, prescaler=0, scan_tick=0
//   - seg_out=all-inactive (7'h7F if ACTIVE_LOW)
//   - dig_sel=all-inactive
// - Prescaler: counts 0..SCAN_DIV-1, wraps to 0.
//   - scan_tick=1 in the cycle after prescaler==SCAN_DIV-1.
//   - On that same wrap edge, index increments; DIGITS-1 wraps to 0.
// - Dead time: in the cycle where scan_tick=1, seg_out and dig_sel are both inactive (anti-ghosting).
//   - Otherwise dig_sel asserts only bit[index].
//   - seg_out = decode(shadow[4*index+:4]).
// - Decode, active-low form {g..a}; ACTIVE_LOW=0 inverts all bits:
//   - 0:1000000   1:1111001   2:0100100   3:0110000   4:0011001
//   - 5:0010010   6:0000010   7:1111000   8:0000000   9:0010000
//   - hex_mode=1: A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
//   - hex_mode=0: 10-15 -> blank 1111111
// - Leading-zero blank: digit k>0 is blank iff blank_lz=1 and all nibbles k..DIGITS-1 are 0.
//   - Blanked digit: dig_sel still asserted, seg_out inactive.
// - Latency: load at edge N updates shadow; seg_out reflects new data at edge N+1 (no dead-time cycle pending).
//   - hex_mode, blank_lz and enable take effect on the next edge.
// - Simultaneous load and index advance on the same edge: new shadow and new index both apply.
//   - Dead-time cycle first, then new digit with new data. No old/new mixing.
// - enable=0: outputs inactive from the next edge.
//   - Prescaler, index and shadow keep updating; load is still honoured.
// - Reset mid-scan: outputs go inactive immediately (async); scan restarts at digit 0.
// CONFIGURATION
// - SEG_DP_EN defined: adds ports dp_in (in, DIGITS) and dp_out (out, 1).
//   - dp_in is captured with load.
//   - dp_out = dp of the active digit, same polarity and dead-time/enable/reset gating as seg_out.
//   - DP is never leading-zero blanked.
// - SEG_DP_EN undefined: no dp ports, no dp logic.
// TESTING (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1)
// - Reset release, enable=1, value_in=16'h1234 loaded:
//   - seg_out=7'h7F and dig_sel=4'hF during reset.
//   - Then dig_sel cycles E,D,B,7 with seg 0011001,0110000,0100100,1111001.
//   - Each digit slot = 3 active cycles + 1 dead cycle.
// - value_in=16'h00A5:
//   - hex_mode=0: digit1 blank, digit0 shows 0010010.
//   - hex_mode=1: digit1 shows 0001000.
// - blank_lz=1, value_in=16'h0000:
//   - digits 3..1 show 1111111 with dig_sel asserted; digit 0 shows 1000000.
//   - value_in=16'h0105: digit3 blank; digits 2,1,0 show 1,0,5.
// - load pulsed on the wrap edge with 16'h9999:
//   - next cycle scan_tick=1, outputs inactive.
//   - Following cycle: new digit shows 0010000; never the old nibble.
// - enable=0 for 10 cycles mid-scan:
//   - dig_sel=4'hF, seg_out=7'h7F throughout.
//   - On re-enable, index equals its free-running position (10 cycles later).
// - Reset asserted mid-slot at digit 2:
//   - outputs inactive same cycle.
//   - After release the scan restarts at digit 0 with shadow=0.
//   - With SEG_DP_EN: dp_in=4'b0100 -> dp_out=0 only in digit-2 slot.

Source files
------------

// File: rtl/seven_seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundles the data/control inputs and display outputs of seven_seg_scan_driver.
//   value_in  : packed 4-bit nibbles, digit 0 in bits [3:0]
//   load      : capture value_in (and dp_in) into the shadow register
//   enable    : 0 darkens the display, scan keeps running
//   hex_mode  : 1 shows A..F for nibbles 10..15, 0 blanks them
//   blank_lz  : 1 suppresses leading zeros (digit 0 always shown)
//   seg_out   : segments {g,f,e,d,c,b,a}
//   dig_sel   : one-hot digit select
//   scan_tick : single-cycle pulse when the active digit advances
// Optional (SEG_DP_EN defined): dp_in per-digit decimal points, dp_out active dp.
// Modports: master = the logic feeding the driver, slave = the driver itself.
// -----------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic                load;
    logic                enable;
    logic                hex_mode;
    logic                blank_lz;
    logic [6:0]          seg_out;
    logic [DIGITS-1:0]   dig_sel;
    logic                scan_tick;
`ifdef SEG_DP_EN
    logic [DIGITS-1:0]   dp_in;
    logic                dp_out;

    modport master (
        output value_in, load, enable, hex_mode, blank_lz, dp_in,
        input  seg_out, dig_sel, scan_tick, dp_out
    );
    modport slave (
        input  value_in, load, enable, hex_mode, blank_lz, dp_in,
        output seg_out, dig_sel, scan_tick, dp_out
    );
`else
    modport master (
        output value_in, load, enable, hex_mode, blank_lz,
        input  seg_out, dig_sel, scan_tick
    );
    modport slave (
        input  value_in, load, enable, hex_mode, blank_lz,
        output seg_out, dig_sel, scan_tick
    );
`endif
endinterface

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed driver for a bank of DIGITS common-select 7-segment digits.
// A shadow register holds the packed nibbles; a prescaler steps through the
// digits, one digit lit per slot, with one dark "dead" cycle at each slot
// change to avoid ghosting. Each nibble is decoded to segments (BCD or hex)
// with optional leading-zero blanking.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset (release synchronised externally)
//   bus   : seven_seg_scan_driver_if.slave (data/control in, display out)
// Parameters: DIGITS (>=2), SCAN_DIV (>=2, clk cycles per digit slot),
//   ACTIVE_LOW (1: segments and selects asserted low).
// Optional feature macro: SEG_DP_EN adds per-digit decimal point (dp_in/dp_out).
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input logic                    clk,
    input logic                    reset,
    seven_seg_scan_driver_if.slave bus
);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]     PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Active-low {g..a} pattern; blank = all ones.
    function automatic logic [6:0] decode_al(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        s = 7'b1111111;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = hex ? 7'b0001000 : 7'b1111111;
            4'hB: s = hex ? 7'b0000011 : 7'b1111111;
            4'hC: s = hex ? 7'b1000110 : 7'b1111111;
            4'hD: s = hex ? 7'b0100001 : 7'b1111111;
            4'hE: s = hex ? 7'b0000110 : 7'b1111111;
            default: s = hex ? 7'b0001110 : 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PW-1:0]       prescaler_reg, prescaler_next;
    logic [IW-1:0]       index_reg, index_next;
    logic [4*DIGITS-1:0] shadow_reg, shadow_next;
    logic                scan_tick_reg, scan_tick_next;
    logic [6:0]          seg_reg, seg_next;
    logic [DIGITS-1:0]   dig_sel_reg, dig_sel_next;

    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   zero_from;   // nibbles gi..DIGITS-1 are all zero
    logic [DIGITS-1:0]   lz_blank;    // digit gi suppressed as a leading zero
    logic [DIGITS-1:0]   onehot;
    logic                wrap;
    logic [6:0]          seg_al;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]    = shadow_reg[4*gi +: 4];
            assign onehot[gi] = (index_reg == IW'(gi));
            if (gi == DIGITS - 1) begin : g_top
                assign zero_from[gi] = (nib[gi] == 4'h0);
            end else begin : g_lower
                assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
            end
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = bus.blank_lz && zero_from[gi];
            end
        end
    endgenerate

    assign wrap = (prescaler_reg == PS_LAST);

    always_comb begin
        prescaler_next = prescaler_reg + PW'(1);
        index_next     = index_reg;
        scan_tick_next = 1'b0;
        shadow_next    = shadow_reg;
        seg_al         = 7'b1111111;
        seg_next       = SEG_OFF;
        dig_sel_next   = DIG_OFF;

        if (bus.load) begin
            shadow_next = bus.value_in;
        end

        if (wrap) begin
            prescaler_next = '0;
            scan_tick_next = 1'b1;
            index_next     = (index_reg == IDX_LAST) ? '0 : index_reg + IW'(1);
        end

        // Outputs use the current shadow/index registers, so a load or index
        // change on the wrap edge is hidden by the dead cycle and the next
        // lit cycle shows the new digit with the new data together.
        if (!lz_blank[index_reg]) begin
            seg_al = decode_al(nib[index_reg], bus.hex_mode);
        end

        if (bus.enable && !wrap) begin
            seg_next     = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
            dig_sel_next = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_reg <= '0;
            index_reg     <= '0;
            shadow_reg    <= '0;
            scan_tick_reg <= 1'b0;
            seg_reg       <= SEG_OFF;
            dig_sel_reg   <= DIG_OFF;
        end else begin
            prescaler_reg <= prescaler_next;
            index_reg     <= index_next;
            shadow_reg    <= shadow_next;
            scan_tick_reg <= scan_tick_next;
            seg_reg       <= seg_next;
            dig_sel_reg   <= dig_sel_next;
        end
    end

    assign bus.seg_out   = seg_reg;
    assign bus.dig_sel   = dig_sel_reg;
    assign bus.scan_tick = scan_tick_reg;

`ifdef SEG_DP_EN
    // Decimal point follows the same gating as the segments but is never
    // leading-zero blanked.
    localparam logic DP_OFF = (ACTIVE_LOW != 0);

    logic [DIGITS-1:0] dp_shadow_reg, dp_shadow_next;
    logic              dp_out_reg, dp_out_next;

    always_comb begin
        dp_shadow_next = bus.load ? bus.dp_in : dp_shadow_reg;
        dp_out_next    = DP_OFF;
        if (bus.enable && !wrap) begin
            dp_out_next = (ACTIVE_LOW != 0) ? ~dp_shadow_reg[index_reg] : dp_shadow_reg[index_reg];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_shadow_reg <= '0;
            dp_out_reg    <= DP_OFF;
        end else begin
            dp_shadow_reg <= dp_shadow_next;
            dp_out_reg    <= dp_out_next;
        end
    end

    assign bus.dp_out = dp_out_reg;
`endif

endmodule
